// File: rtl/wb_arbiter.sv
// wb_arbiter: write-back arbiter for the register file's single write port.
// Pipeline results always win; aux (mul/div) results queue in a DEPTH-entry
// FIFO and drain in idle write-back slots. busy_mask flags registers with a
// queued live aux write.
// Optional: define WB_ARB_PERF_EN to add perf_aux_stall / perf_deferred counters.
module wb_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_valid,
  input  logic [4:0]        pipe_waddr,
  input  logic [31:0]       pipe_wdata,
  input  logic              aux_valid,
  output logic              aux_ready,
  input  logic [4:0]        aux_waddr,
  input  logic [31:0]       aux_wdata,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic [31:0]       busy_mask
`ifdef WB_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_aux_stall,
  output logic [CNT_W-1:0]  perf_deferred
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [4:0]       addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] live_q, live_d;
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_waddr_q, rf_waddr_d;
  logic [31:0]      rf_wdata_q, rf_wdata_d;

  logic full, empty, pipe_wr, push, pop, head_live;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign aux_ready = !rst && !full;
  assign pipe_wr   = pipe_valid && (pipe_waddr != 5'd0);
  assign push      = aux_valid && aux_ready && (aux_waddr != 5'd0);
  assign head_live = live_q[head_q];
  // Pop decision uses start-of-cycle liveness: a head killed this cycle pops next cycle.
  assign pop       = !empty && (!pipe_wr || !head_live);

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  // Next-state: WAW kill, pop/push bookkeeping and the write-port decision.
  always_comb begin
    live_d     = live_q;
    head_d     = head_q;
    tail_d     = tail_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (pipe_wr) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (live_q[i] && (addr_q[i] == pipe_waddr)) live_d[i] = 1'b0;
      end
    end
    if (pop) begin
      live_d[head_q] = 1'b0;
      head_d         = head_q + 1'b1;
    end
    if (pipe_wr) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = pipe_waddr;
      rf_wdata_d = pipe_wdata;
    end else if (pop && head_live) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = addr_q[head_q];
      rf_wdata_d = data_q[head_q];
    end
    // Push applied after the kill so a same-cycle aux entry counts as younger.
    if (push) begin
      live_d[tail_q] = 1'b1;
      tail_d         = tail_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Control state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      live_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      live_q     <= live_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // FIFO payload storage; validity is tracked solely by live_q.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= aux_waddr;
      data_q[tail_q] <= aux_wdata;
    end
  end

  // Pending-write mask from live entries; r0 never reported.
  always_comb begin
    busy_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (live_q[i]) busy_mask[addr_q[i]] = 1'b1;
    end
    busy_mask[0] = 1'b0;
  end

`ifdef WB_ARB_PERF_EN
  logic [CNT_W-1:0] stall_q, stall_d, defer_q, defer_d;

  assign perf_aux_stall = stall_q;
  assign perf_deferred  = defer_q;

  // Counter increments: aux refused, and live head bypassed by a pipe write.
  always_comb begin
    stall_d = stall_q;
    defer_d = defer_q;
    if (aux_valid && !aux_ready)          stall_d = stall_q + 1'b1;
    if (!empty && head_live && pipe_wr)   defer_d = defer_q + 1'b1;
  end

  // Performance counter registers, wrapping on overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      defer_q <= '0;
    end else begin
      stall_q <= stall_d;
      defer_q <= defer_d;
    end
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios then random traffic, checked
// against a queue-based model of the arbitration rules.
module tb_wb_arbiter;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid, aux_valid, aux_ready, rf_we;
  logic [4:0]  pipe_waddr, aux_waddr, rf_waddr;
  logic [31:0] pipe_wdata, aux_wdata, rf_wdata, busy_mask;

  wb_arbiter #(.DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .aux_valid(aux_valid), .aux_ready(aux_ready),
    .aux_waddr(aux_waddr), .aux_wdata(aux_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    bit          live;
  } ent_t;

  ent_t        mq[$];
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (mq[i]) if (mq[i].live) m[mq[i].a] = 1'b1;
    return m;
  endfunction

  // Apply one cycle of inputs, check outputs, advance the model across the edge.
  task automatic cyc(input logic r, input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                     input logic av, input logic [4:0] aa, input logic [31:0] ad);
    bit ready, pw, do_pop;
    ent_t h;
    rst = r; pipe_valid = pv; pipe_waddr = pa; pipe_wdata = pd;
    aux_valid = av; aux_waddr = aa; aux_wdata = ad;
    #1;
    ready = !r && (mq.size() < DEPTH);
    chk("aux_ready", {31'd0, aux_ready}, {31'd0, ready});
    chk("rf_we", {31'd0, rf_we}, {31'd0, m_we});
    chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_waddr});
    chk("rf_wdata", rf_wdata, m_wdata);
    chk("busy_mask", busy_mask, model_mask());
    if (r) begin
      mq.delete();
      m_we = 1'b0; m_waddr = '0; m_wdata = '0;
    end else begin
      pw     = pv && (pa != 0);
      do_pop = (mq.size() > 0) && (!pw || !mq[0].live);
      if (do_pop) h = mq[0];
      m_we = 1'b0;
      if (pw) begin
        m_we = 1'b1; m_waddr = pa; m_wdata = pd;
      end else if (do_pop && h.live) begin
        m_we = 1'b1; m_waddr = h.a; m_wdata = h.d;
      end
      if (pw) foreach (mq[i]) if (mq[i].a == pa) mq[i].live = 1'b0;
      if (do_pop) void'(mq.pop_front());
      if (av && ready && aa != 0) mq.push_back('{a: aa, d: ad, live: 1'b1});
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; pipe_valid = 0; pipe_waddr = 0; pipe_wdata = 0;
    aux_valid = 0; aux_waddr = 0; aux_wdata = 0;
    m_we = 0; m_waddr = 0; m_wdata = 0;
    @(negedge clk);
    @(negedge clk);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("reset_we", {31'd0, rf_we}, 32'd0);
    chk("reset_mask", busy_mask, 32'd0);

    // Pipe write r5
    cyc(0, 1, 5, 32'h1234, 0, 0, 0);
    chk("pipe_r5_we", {31'd0, rf_we}, 32'd1);
    chk("pipe_r5_data", rf_wdata, 32'h1234);
    idle(2);

    // Single aux push r7
    cyc(0, 0, 0, 0, 1, 7, 32'hAAAA);
    chk("aux_r7_busy", busy_mask, 32'h80);
    idle(3);

    // Fill FIFO under continuous pipe writes, 5th aux stalls, then drain
    for (int i = 1; i <= 5; i++) cyc(0, 1, 5'(10 + i), 32'(i), 1, 5'(i), 32'(100 + i));
    chk("full_ready", {31'd0, aux_ready}, 32'd0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1, 5, 32'd105);
    idle(4);

    // WAW kill r9
    cyc(0, 0, 0, 0, 1, 9, 32'h1);
    cyc(0, 1, 9, 32'h2, 0, 0, 0);
    chk("kill_mask", busy_mask, 32'h0);
    idle(3);

    // Same-cycle pipe r3 and aux r3
    cyc(0, 1, 3, 32'h33, 1, 3, 32'h44);
    idle(3);
    chk("r3_final", rf_wdata, 32'h44);

    // r0 requests
    cyc(0, 1, 0, 32'h5, 1, 0, 32'h6);
    idle(2);
    chk("r0_mask", busy_mask, 32'h0);

    // Reset with 3 entries queued
    for (int i = 0; i < 3; i++) cyc(0, 1, 20, 32'(i), 1, 5'(21 + i), 32'(i));
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("rst_mask", busy_mask, 32'h0);
    chk("rst_we", {31'd0, rf_we}, 32'd0);

    // Random traffic with narrow address range to provoke collisions
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom_range(0, 63) == 0),
          ($urandom_range(0, 99) < 55), 5'($urandom_range(0, 7)), $urandom,
          ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom);
    end
    idle(DEPTH + 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
